// File: rtl/if_else_split_gen_pkg.sv
// rtl/if_else_split_gen_pkg.sv - shared defaults and branch constants for the if/else splitter
package if_else_split_gen_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W_DEF  = 16;

  localparam logic BR_IF   = 1'b1;
  localparam logic BR_ELSE = 1'b0;

  // A full branch can still take a word when its head leaves on the same edge.
  function automatic logic can_accept(input logic full, input logic pop);
    return !full || pop;
  endfunction

endpackage

// File: rtl/if_else_split_gen_if.sv
// rtl/if_else_split_gen_if.sv - combined-word input, if/else output channels and counter status
interface if_else_split_gen_if
  import if_else_split_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_cond;

  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_data;

  logic              else_valid;
  logic              else_ready;
  logic [DATA_W-1:0] else_data;

  logic [CNT_W-1:0]  if_count;
  logic [CNT_W-1:0]  else_count;
  logic              clr_counts;

  modport master (
    output in_valid, in_data, in_cond, if_ready, else_ready, clr_counts,
    input  in_ready, if_valid, if_data, else_valid, else_data, if_count, else_count
  );

  modport slave (
    input  in_valid, in_data, in_cond, if_ready, else_ready, clr_counts,
    output in_ready, if_valid, if_data, else_valid, else_data, if_count, else_count
  );

endinterface

// File: rtl/if_else_split_gen_seg_branch_fifo.sv
// rtl/if_else_split_gen_seg_branch_fifo.sv - per-branch word FIFO with head output, 0 when empty
module seg_branch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_else_split_gen.sv
// rtl/if_else_split_gen.sv - steers condition-tagged words into buffered if/else channels
module if_else_split_gen
  import if_else_split_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  if_else_split_gen_if.slave bus
);

  logic              w_if_full;
  logic              w_if_empty;
  logic              w_if_pop;
  logic              w_if_push;
  logic [DATA_W-1:0] w_if_head;
  logic              w_else_full;
  logic              w_else_empty;
  logic              w_else_pop;
  logic              w_else_push;
  logic [DATA_W-1:0] w_else_head;
  logic              w_accept;
  logic [CNT_W-1:0]  r_if_count;
  logic [CNT_W-1:0]  r_else_count;

  assign w_if_pop   = bus.if_ready & ~w_if_empty;
  assign w_else_pop = bus.else_ready & ~w_else_empty;

  assign bus.in_ready = (bus.in_cond == BR_IF) ? can_accept(w_if_full, w_if_pop)
                                               : can_accept(w_else_full, w_else_pop);

  assign w_accept    = bus.in_valid & bus.in_ready;
  assign w_if_push   = w_accept & (bus.in_cond == BR_IF);
  assign w_else_push = w_accept & (bus.in_cond == BR_ELSE);

  seg_branch_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_if_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_if_push),
    .i_data  (bus.in_data),
    .i_pop   (w_if_pop),
    .o_full  (w_if_full),
    .o_empty (w_if_empty),
    .o_head  (w_if_head)
  );

  seg_branch_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_else_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_else_push),
    .i_data  (bus.in_data),
    .i_pop   (w_else_pop),
    .o_full  (w_else_full),
    .o_empty (w_else_empty),
    .o_head  (w_else_head)
  );

  assign bus.if_valid   = ~w_if_empty;
  assign bus.if_data    = w_if_head;
  assign bus.else_valid = ~w_else_empty;
  assign bus.else_data  = w_else_head;

  // Clear wins over a same-cycle accept so software sees a clean zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_count   <= '0;
      r_else_count <= '0;
    end else if (bus.clr_counts) begin
      r_if_count   <= '0;
      r_else_count <= '0;
    end else begin
      if (w_if_push) begin
        r_if_count <= r_if_count + CNT_W'(1);
      end
      if (w_else_push) begin
        r_else_count <= r_else_count + CNT_W'(1);
      end
    end
  end

  assign bus.if_count   = r_if_count;
  assign bus.else_count = r_else_count;

endmodule

// File: tb/tb_if_else_split_gen.sv
// tb/tb_if_else_split_gen.sv - directed and random checks of the if/else splitter
module tb_if_else_split_gen;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  if_else_split_gen_if #(.DATA_W(32), .CNT_W(16)) bus ();

  if_else_split_gen #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic c);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_cond  = c;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!bus.in_ready) begin
      n_fail++;
      $display("FAIL push_timeout data=%h cond=%0d in_ready=%0d required 1", d, c, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_and_clear();
    bus.in_valid   = 1'b0;
    bus.if_ready   = 1'b1;
    bus.else_ready = 1'b1;
    repeat (6) tick();
    bus.clr_counts = 1'b1;
    tick();
    bus.clr_counts = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.if_valid !== 1'b0 || bus.else_valid !== 1'b0 || bus.if_data !== 32'h0 ||
        bus.else_data !== 32'h0 || bus.if_count !== 16'h0 || bus.else_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b/%b d=%h/%h c=%h/%h required all 0",
               bus.if_valid, bus.else_valid, bus.if_data, bus.else_data, bus.if_count, bus.else_count);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
    end
    reset = 1'b1;
    tick();
    bus.if_ready   = 1'b0;
    bus.else_ready = 1'b0;
    push_word(32'h1111_0001, 1'b1);
    push_word(32'h1111_0002, 1'b1);
    push_word(32'h2222_0001, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.if_valid !== 1'b1 || bus.else_valid !== 1'b1 || bus.if_count !== 16'd2 || bus.else_count !== 16'd1) begin
      n_fail++;
      $display("FAIL pre_reset_fill got v=%b/%b c=%0d/%0d required 1/1 2/1",
               bus.if_valid, bus.else_valid, bus.if_count, bus.else_count);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.if_valid !== 1'b0 || bus.else_valid !== 1'b0 || bus.if_data !== 32'h0 ||
        bus.if_count !== 16'h0 || bus.else_count !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset_clear got v=%b/%b d=%h c=%0d/%0d required 0",
               bus.if_valid, bus.else_valid, bus.if_data, bus.if_count, bus.else_count);
    end
    tick();
    reset = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      bus.in_cond = c[0];
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.if_valid !== 1'b0 || bus.else_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset cond=%0d got ready=%b v=%b/%b required 1 0/0",
                 c, bus.in_ready, bus.if_valid, bus.else_valid);
      end
    end
    tick();
  endtask

  task automatic test_routing();
    drain_and_clear();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA5A5_0001;
    bus.in_cond  = 1'b1;
    tick();
    bus.in_data  = 32'h5A5A_0002;
    bus.in_cond  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.if_valid !== 1'b1 || bus.if_data !== 32'hA5A5_0001 || bus.else_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL route_if got v=%b d=%h ev=%b required 1 a5a50001 0",
               bus.if_valid, bus.if_data, bus.else_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.else_valid !== 1'b1 || bus.else_data !== 32'h5A5A_0002 || bus.if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL route_else got v=%b d=%h iv=%b required 1 5a5a0002 0",
               bus.else_valid, bus.else_data, bus.if_valid);
    end
    n_checks++;
    if (bus.if_count !== 16'd1 || bus.else_count !== 16'd1) begin
      n_fail++;
      $display("FAIL route_counts got %0d/%0d required 1/1", bus.if_count, bus.else_count);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [5];
    drain_and_clear();
    for (int i = 0; i < 5; i++) exp_w[i] = 32'h1000_0000 + i;
    bus.if_ready   = 1'b0;
    bus.else_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(exp_w[i], 1'b1);
    bus.in_cond = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.if_count !== 16'd4) begin
      n_fail++;
      $display("FAIL bp_full_if got ready=%b count=%0d required 0 4", bus.in_ready, bus.if_count);
    end
    bus.in_cond = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_else_ready got %b required 1", bus.in_ready);
    end
    tick();
    push_word(32'hEEEE_0001, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.else_valid !== 1'b1 || bus.else_data !== 32'hEEEE_0001) begin
      n_fail++;
      $display("FAIL bp_else_flow got v=%b d=%h required 1 eeee0001", bus.else_valid, bus.else_data);
    end
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = exp_w[4];
    bus.in_cond  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold got ready=%b required 0", bus.in_ready);
      end
      tick();
    end
    bus.if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.if_valid !== 1'b1 || bus.if_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL bp_order[%0d] got v=%b d=%h required 1 %h", i, bus.if_valid, bus.if_data, exp_w[i]);
      end
      tick();
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (bus.if_valid !== 1'b0 || bus.if_count !== 16'd5 || bus.else_count !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_final got v=%b counts=%0d/%0d required 0 5/1", bus.if_valid, bus.if_count, bus.else_count);
    end
    tick();
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_w [5];
    drain_and_clear();
    for (int i = 0; i < 5; i++) exp_w[i] = 32'hF0F0_0000 + i;
    bus.if_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(exp_w[i], 1'b1);
    bus.if_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = exp_w[4];
    bus.in_cond  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.if_data !== exp_w[0]) begin
      n_fail++;
      $display("FAIL fpp_accept got ready=%b d=%h required 1 %h", bus.in_ready, bus.if_data, exp_w[0]);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.if_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.if_data !== exp_w[1]) begin
      n_fail++;
      $display("FAIL fpp_still_full got ready=%b d=%h required 0 %h", bus.in_ready, bus.if_data, exp_w[1]);
    end
    tick();
    bus.if_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.if_valid !== 1'b1 || bus.if_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL fpp_order[%0d] got v=%b d=%h required 1 %h", i, bus.if_valid, bus.if_data, exp_w[i]);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (bus.if_valid !== 1'b0 || bus.if_count !== 16'd5) begin
      n_fail++;
      $display("FAIL fpp_final got v=%b count=%0d required 0 5", bus.if_valid, bus.if_count);
    end
    tick();
  endtask

  task automatic test_counter_wrap_clear();
    drain_and_clear();
    bus.in_cond  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      bus.in_data = i;
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.if_count !== 16'hFFFF || bus.else_count !== 16'h0) begin
      n_fail++;
      $display("FAIL wrap_preload got %h/%h required ffff/0000", bus.if_count, bus.else_count);
    end
    tick();
    push_word(32'hDEAD_0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.if_count !== 16'h0) begin
      n_fail++;
      $display("FAIL wrap_to_zero got %h required 0000", bus.if_count);
    end
    tick();
    push_word(32'hDEAD_0001, 1'b1);
    push_word(32'hDEAD_0002, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.if_count !== 16'd1 || bus.else_count !== 16'd1) begin
      n_fail++;
      $display("FAIL count_after_wrap got %0d/%0d required 1/1", bus.if_count, bus.else_count);
    end
    tick();
    bus.clr_counts = 1'b1;
    push_word(32'hDEAD_0003, 1'b1);
    bus.clr_counts = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.if_count !== 16'h0 || bus.else_count !== 16'h0) begin
      n_fail++;
      $display("FAIL clr_priority got %0d/%0d required 0/0", bus.if_count, bus.else_count);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] q_if[$];
    logic [31:0] q_else[$];
    logic [31:0] exp_d;
    logic        hold;
    logic        exp_ready;
    logic        if_pop;
    logic        else_pop;
    int          sent;
    int          n_if;
    int          n_else;
    int          cycles;
    drain_and_clear();
    hold   = 1'b0;
    sent   = 0;
    n_if   = 0;
    n_else = 0;
    cycles = 0;
    while ((sent < 3000 || q_if.size() != 0 || q_else.size() != 0) && cycles < 40000) begin
      if (!hold) begin
        bus.in_valid = (sent < 3000) && ($urandom_range(3) != 0);
        bus.in_data  = $urandom;
        bus.in_cond  = $urandom_range(1);
      end
      bus.if_ready   = $urandom_range(3) != 0;
      bus.else_ready = $urandom_range(2) != 0;
      @(negedge clk);
      if_pop   = bus.if_valid && bus.if_ready;
      else_pop = bus.else_valid && bus.else_ready;
      exp_ready = bus.in_cond ? (q_if.size() < 4 || (q_if.size() != 0 && bus.if_ready))
                              : (q_else.size() < 4 || (q_else.size() != 0 && bus.else_ready));
      n_checks++;
      if (bus.in_ready !== exp_ready || bus.if_valid !== (q_if.size() != 0) ||
          bus.else_valid !== (q_else.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_flags cyc=%0d got r=%b v=%b/%b required %b %b/%b", cycles, bus.in_ready,
                 bus.if_valid, bus.else_valid, exp_ready, q_if.size() != 0, q_else.size() != 0);
      end
      if (if_pop) begin
        exp_d = (q_if.size() != 0) ? q_if.pop_front() : 32'hXXXX_XXXX;
        n_checks++;
        if (bus.if_data !== exp_d) begin
          n_fail++;
          $display("FAIL rnd_if_data cyc=%0d got %h required %h", cycles, bus.if_data, exp_d);
        end
      end
      if (else_pop) begin
        exp_d = (q_else.size() != 0) ? q_else.pop_front() : 32'hXXXX_XXXX;
        n_checks++;
        if (bus.else_data !== exp_d) begin
          n_fail++;
          $display("FAIL rnd_else_data cyc=%0d got %h required %h", cycles, bus.else_data, exp_d);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        if (bus.in_cond) begin
          q_if.push_back(bus.in_data);
          n_if++;
        end else begin
          q_else.push_back(bus.in_data);
          n_else++;
        end
      end
      hold = bus.in_valid && !bus.in_ready;
      tick();
      cycles++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (cycles >= 40000) begin
      n_fail++;
      $display("FAIL rnd_timeout sent=%0d left=%0d/%0d required all drained", sent, q_if.size(), q_else.size());
    end
    @(negedge clk);
    n_checks++;
    if (bus.if_count !== 16'(n_if) || bus.else_count !== 16'(n_else)) begin
      n_fail++;
      $display("FAIL rnd_counts got %0d/%0d required %0d/%0d", bus.if_count, bus.else_count, n_if, n_else);
    end
    tick();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 32'h0;
    bus.in_cond    = 1'b0;
    bus.if_ready   = 1'b0;
    bus.else_ready = 1'b0;
    bus.clr_counts = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_routing();
    test_backpressure();
    test_full_push_pop();
    test_counter_wrap_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
